parallax_scroll_ctrl: RTL and testbench

Per-frame scroll scheduler for the five-layer parallax VGA background. It holds a programmable speed and a fractional position accumulator for each layer's X and Y axis. On every frame boundary, detected on the `vsync` output of the sync generator, it sequences one accumulator update per clock across all ten lanes. The pixel datapath consumes the integer scroll offsets, and a byte-wide valid/ready port reprograms speeds at run time.

---
 rtl/parallax_scroll_ctrl.sv | 139 +++++++++++++
 tb/tb_parallax_scroll_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/parallax_scroll_ctrl.sv
// rtl/parallax_scroll_ctrl.sv - per-frame parallax scroll scheduler, one lane update per clock
// Optional feature macro: PARALLAX_REVERSE_EN (per-lane reverse direction bit).
module parallax_scroll_ctrl #(
  parameter int LANES = 10,
  parameter int FRAC  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vsync,
  input  logic                  pause,
  input  logic                  step,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [3:0]            cfg_addr,
  input  logic [8:0]            cfg_data,
  output logic [10*LANES-1:0]   offs,
  output logic [9:0]            frame_cnt,
  output logic                  busy,
  output logic                  overrun
);

  localparam int ACC_W = 10 + FRAC;

  typedef enum logic {S_IDLE, S_UPDATE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       idx, idx_nxt;
  logic             vsync_q;
  logic             pending;
  logic             step_armed;
  logic [ACC_W-1:0] acc   [LANES];
  logic [7:0]       speed [LANES];
`ifdef PARALLAX_REVERSE_EN
  logic             dir   [LANES];
`else
  logic             unused_cfg_dir;
  assign unused_cfg_dir = cfg_data[8];
`endif

  function automatic logic [7:0] reset_speed(input int lane);
    case (lane)
      0:       reset_speed = 8'd8;
      1:       reset_speed = 8'd16;
      2:       reset_speed = 8'd56;
      3:       reset_speed = 8'd12;
      4:       reset_speed = 8'd128;
      5:       reset_speed = 8'd4;
      6:       reset_speed = 8'd16;
      7:       reset_speed = 8'd2;
      8:       reset_speed = 8'd4;
      9:       reset_speed = 8'd1;
      default: reset_speed = 8'd0;
    endcase
  endfunction

  logic frame_edge, req, cfg_hs, last_lane;
  assign frame_edge = vsync & ~vsync_q;
  assign req        = frame_edge & (~pause | step_armed);
  assign cfg_ready  = (state == S_IDLE);
  assign cfg_hs     = cfg_valid & cfg_ready;
  assign last_lane  = (state == S_UPDATE) && (idx == 4'(LANES - 1));
  assign busy       = (state == S_UPDATE);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      S_IDLE: begin
        if (req || pending) begin
          state_nxt = S_UPDATE;
          idx_nxt   = 4'd0;
        end
      end
      S_UPDATE: begin
        idx_nxt = idx + 4'd1;
        if (last_lane) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= 4'd0;
      vsync_q    <= 1'b0;
      pending    <= 1'b0;
      step_armed <= 1'b0;
      overrun    <= 1'b0;
      frame_cnt  <= 10'd0;
      for (int i = 0; i < LANES; i++) begin
        acc[i]   <= '0;
        speed[i] <= reset_speed(i);
`ifdef PARALLAX_REVERSE_EN
        dir[i]   <= 1'b0;
`endif
      end
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      vsync_q    <= vsync;
      // A new step pulse wins over the edge that consumes an older one.
      step_armed <= step | (step_armed & ~req);

      // In IDLE a queued sweep starts; a coincident fresh request stays queued.
      if (state == S_IDLE) begin
        pending <= pending & req;
      end else if (req) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end

      if (cfg_hs && cfg_addr == 4'd15) overrun <= 1'b0;
      if (last_lane) frame_cnt <= frame_cnt + 10'd1;

      for (int i = 0; i < LANES; i++) begin
        if (state == S_UPDATE && idx == 4'(i)) begin
`ifdef PARALLAX_REVERSE_EN
          if (dir[i]) acc[i] <= acc[i] - {{(ACC_W-8){1'b0}}, speed[i]};
          else        acc[i] <= acc[i] + {{(ACC_W-8){1'b0}}, speed[i]};
`else
          acc[i] <= acc[i] + {{(ACC_W-8){1'b0}}, speed[i]};
`endif
        end
        if (cfg_hs && cfg_addr == 4'(i)) begin
          speed[i] <= cfg_data[7:0];
`ifdef PARALLAX_REVERSE_EN
          dir[i]   <= cfg_data[8];
`endif
        end
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_offs
    assign offs[10*g +: 10] = acc[g][ACC_W-1:FRAC];
  end

endmodule

// File: tb/tb_parallax_scroll_ctrl.sv
// tb/tb_parallax_scroll_ctrl.sv - randomized self-checking bench for parallax_scroll_ctrl
module tb_parallax_scroll_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, vsync, pause, step, cfg_valid, cfg_ready;
  logic [3:0]  cfg_addr;
  logic [8:0]  cfg_data;
  logic [99:0] offs;
  logic [9:0]  frame_cnt;
  logic        busy, overrun;

  parallax_scroll_ctrl #(.LANES(10), .FRAC(3)) dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .pause(pause), .step(step),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .offs(offs), .frame_cnt(frame_cnt), .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [99:0] got, input logic [99:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: a whole frame moves every lane by its speed at once.
  int macc [10];
  int mspd [10];
  bit mdir [10];
  int mcnt;
  bit marmed;

  function automatic void model_reset();
    int defaults [10] = '{8, 16, 56, 12, 128, 4, 16, 2, 4, 1};
    for (int i = 0; i < 10; i++) begin
      macc[i] = 0;
      mspd[i] = defaults[i];
      mdir[i] = 1'b0;
    end
    mcnt   = 0;
    marmed = 1'b0;
  endfunction

  function automatic void model_frame(input bit paused);
    if (!paused || marmed) begin
      for (int i = 0; i < 10; i++)
        macc[i] = mdir[i] ? (macc[i] - mspd[i]) & 8191 : (macc[i] + mspd[i]) & 8191;
      mcnt   = (mcnt + 1) % 1024;
      marmed = 1'b0;
    end
  endfunction

  function automatic logic [99:0] model_offs();
    logic [99:0] r;
    for (int i = 0; i < 10; i++) r[10*i +: 10] = 10'(macc[i] >> 3);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; vsync = 1'b0; pause = 1'b0; step = 1'b0;
    cfg_valid = 1'b0; cfg_addr = 4'd0; cfg_data = 9'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic frame_and_check(input string tag);
    vsync = 1'b1;
    model_frame(pause);
    tick();
    vsync = 1'b0;
    repeat (13) tick();
    check({tag, "_offs"}, offs, model_offs());
    check({tag, "_cnt"}, 100'(frame_cnt), 100'(mcnt));
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [8:0] d);
    int w;
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
    w = 0;
    while (!cfg_ready && w < 50) begin
      tick();
      w++;
    end
    check("cfg_wait", 100'(w < 50), 100'(1));
    tick();
    cfg_valid = 1'b0;
    if (a < 4'd10) begin
      mspd[a] = int'(d[7:0]);
`ifdef PARALLAX_REVERSE_EN
      mdir[a] = d[8];
`endif
    end
  endtask

  initial begin
    int nb, gap_low;
    logic [9:0] lane0_before;
    logic [3:0] ra;

    do_reset();
    check("rst_offs", offs, 100'd0);
    check("rst_cnt", 100'(frame_cnt), 100'd0);
    check("rst_busy", 100'(busy), 100'd0);
    check("rst_overrun", 100'(overrun), 100'd0);
    check("rst_ready", 100'(cfg_ready), 100'd1);

    // Single frame: busy length and known offsets.
    nb = 0;
    model_frame(1'b0);
    for (int k = 0; k < 20; k++) begin
      vsync = (k == 0);
      tick();
      if (busy) nb++;
    end
    check("one_busy_len", 100'(nb), 100'd10);
    check("one_lane0", 100'(offs[9:0]), 100'd1);
    check("one_lane1", 100'(offs[19:10]), 100'd2);
    check("one_lane2", 100'(offs[29:20]), 100'd7);
    check("one_lane4", 100'(offs[49:40]), 100'd16);
    check("one_lane5", 100'(offs[59:50]), 100'd0);
    check("one_cnt", 100'(frame_cnt), 100'd1);
    check("one_offs", offs, model_offs());

    // 128 frames: lane4 wraps to zero.
    do_reset();
    for (int f = 0; f < 128; f++) frame_and_check("wrap");
    check("wrap_lane4", 100'(offs[49:40]), 100'd0);
    check("wrap_lane0", 100'(offs[9:0]), 100'd128);
    check("wrap_cnt", 100'(frame_cnt), 100'd128);

    // Paused edges plus one step.
    do_reset();
    pause = 1'b1;
    for (int f = 0; f < 3; f++) frame_and_check("pause");
    step = 1'b1; marmed = 1'b1;
    tick();
    step = 1'b0;
    for (int f = 0; f < 2; f++) frame_and_check("step");
    check("step_cnt", 100'(frame_cnt), 100'd1);
    pause = 1'b0;

    // Config write held off during a sweep.
    do_reset();
    vsync = 1'b1;
    model_frame(1'b0);
    tick();
    vsync = 1'b0;
    tick();
    cfg_valid = 1'b1; cfg_addr = 4'd0; cfg_data = 9'd0;
    tick();
    check("cfg_ready_busy", 100'(cfg_ready), 100'd0);
    cfg_write(4'd0, 9'd0);
    lane0_before = offs[9:0];
    frame_and_check("frozen");
    check("frozen_lane0", 100'(offs[9:0]), 100'(lane0_before));

    // Three edges 3 cycles apart: one sweep, one pending sweep, overrun.
    do_reset();
    nb = 0; gap_low = 0;
    model_frame(1'b0);
    model_frame(1'b0);
    for (int k = 0; k < 30; k++) begin
      vsync = (k == 0 || k == 3 || k == 6);
      tick();
      if (busy) nb++;
      if (k == 10 && !busy) gap_low = 1;
    end
    check("ovr_busy_len", 100'(nb), 100'd20);
    check("ovr_gap", 100'(gap_low), 100'd1);
    check("ovr_flag", 100'(overrun), 100'd1);
    check("ovr_offs", offs, model_offs());
    check("ovr_cnt", 100'(frame_cnt), 100'(mcnt));
    cfg_write(4'd15, 9'd0);
    check("ovr_clear", 100'(overrun), 100'd0);

`ifdef PARALLAX_REVERSE_EN
    do_reset();
    cfg_write(4'd0, 9'h108);
    frame_and_check("rev");
    check("rev_lane0", 100'(offs[9:0]), 100'd1023);
`endif

    // Randomized pause/step/config traffic between frames.
    do_reset();
    for (int it = 0; it < 60; it++) begin
      pause = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        step = 1'b1; marmed = 1'b1;
        tick();
        step = 1'b0;
      end
      if ($urandom_range(0, 1) == 1) begin
        ra = 4'($urandom_range(0, 15));
        cfg_write(ra, 9'($urandom));
      end
      frame_and_check("rand");
    end
    pause = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
